// File: rtl/io_ram_datapath_p_if.sv
// Load/store port between the core (ALU address, rs2 store data) and the RAM/IO datapath.
// The core drives address/data/strobes; the datapath returns combinational load data and the misalign flag.
interface io_ram_datapath_p_if;
    logic [31:0] address;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [1:0]  mem_ctrl;
    logic [31:0] rd;
    logic        misalign;

    modport master (output address, wd, we, re, mem_ctrl, input rd, misalign);
    modport slave  (input address, wd, we, re, mem_ctrl, output rd, misalign);
endinterface

// File: rtl/io_ram_datapath_p.sv
// io_ram_datapath_p: decodes one load/store port into data RAM, GPIO and a UART RX (FIFO + sticky flags); IO_RAM_RX_IRQ_EN adds rx_irq.
// Latency: loads are combinational, all state (RAM, GPIO, FIFO, flags, RX FSM) updates on the clk rising edge.
// Backpressure: none; a received byte that finds the FIFO full (and no pop that cycle) is dropped and sets overflow.
module io_ram_datapath_p #(
    parameter int          RAM_WORDS     = 256,
    parameter logic [31:0] IO_BASE       = 32'h0040_0000,
    parameter int          CLK_DIV       = 16,
    parameter int          RX_FIFO_DEPTH = 4,
    parameter int          GPIO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    io_ram_datapath_p_if.slave    bus,
    input  logic                  rx,
    output logic [GPIO_W-1:0]     gpio_out
`ifdef IO_RAM_RX_IRQ_EN
    ,
    output logic                  rx_irq
`endif
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] T_FULL = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    logic [31:0]   ram_mem  [RAM_WORDS];
    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];

    rx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, fe_q, fe_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic          irq_en_q, irq_en_d, irq_q, irq_d;

    logic          in_io, is_gpio, is_status, is_rxdata, mis, wr_ok, ram_we;
    logic [15:0]   io_off;
    logic [AW-1:0] ram_idx;
    logic [3:0]    be;
    logic [31:0]   wdat, rd_v, status_v;
    logic          push_req, frame_err, push_acc, pop, full;

    // The IO window is 64 KiB aligned, so the upper half-word alone identifies it.
    assign in_io     = bus.address[31:16] == IO_BASE[31:16];
    assign io_off    = bus.address[15:0];
    assign is_gpio   = in_io && io_off == 16'h0000;
    assign is_status = in_io && io_off == 16'h0004;
    assign is_rxdata = in_io && io_off == 16'h0008;
    assign ram_idx   = bus.address[AW+1:2];
    assign mis       = (bus.mem_ctrl == 2'b01 && bus.address[0]) ||
                       (bus.mem_ctrl[1] && bus.address[1:0] != 2'b00);
    assign wr_ok     = bus.we && !mis;
    assign ram_we    = wr_ok && !in_io;

    always_comb begin
        be   = 4'b1111;
        wdat = bus.wd;
        case (bus.mem_ctrl)
            2'b00: begin
                be   = 4'b0001 << bus.address[1:0];
                wdat = {4{bus.wd[7:0]}};
            end
            2'b01: begin
                be   = bus.address[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.wd[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram_mem[ram_idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    // RX framing; only the synchronised line value is ever looked at.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    state_d   = S_IDLE;
                    push_req  = rx_s2_q;
                    frame_err = !rx_s2_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign full     = cnt_q == CW'(RX_FIFO_DEPTH);
    assign pop      = bus.re && is_rxdata && cnt_q != '0;
    assign push_acc = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_acc, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        fe_d  = fe_q;
        if (wr_ok && is_status && bus.wd[1]) ovf_d = 1'b0;
        if (wr_ok && is_status && bus.wd[2]) fe_d  = 1'b0;
        if (push_req && !push_acc)           ovf_d = 1'b1;
        if (frame_err)                       fe_d  = 1'b1;
        gpio_d = gpio_q;
        if (wr_ok && is_gpio && bus.mem_ctrl[1]) gpio_d = bus.wd[GPIO_W-1:0];
        irq_en_d = irq_en_q;
        irq_d    = 1'b0;
`ifdef IO_RAM_RX_IRQ_EN
        if (wr_ok && is_status && bus.mem_ctrl[1]) irq_en_d = bus.wd[4];
        irq_d = irq_en_q && (cnt_q != '0 || ovf_q || fe_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            fe_q      <= 1'b0;
            gpio_q    <= '0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            fe_q      <= fe_d;
            gpio_q    <= gpio_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        status_v       = '0;
        status_v[0]    = cnt_q != '0;
        status_v[1]    = ovf_q;
        status_v[2]    = fe_q;
        status_v[4]    = irq_en_q;
        status_v[15:8] = 8'(cnt_q);
        rd_v = '0;
        if (!in_io)                        rd_v = ram_mem[ram_idx];
        else if (is_gpio)                  rd_v[GPIO_W-1:0] = gpio_q;
        else if (is_status)                rd_v = status_v;
        else if (is_rxdata && cnt_q != '0) rd_v[7:0] = fifo_mem[rd_ptr_q];
    end

    assign bus.rd       = rd_v;
    assign bus.misalign = mis;
    assign gpio_out     = gpio_q;
`ifdef IO_RAM_RX_IRQ_EN
    assign rx_irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q ^ irq_en_d;
`endif
endmodule

// File: tb/tb_io_ram_datapath_p.sv
// Bench for io_ram_datapath_p: directed test-plan cases plus random load/store/UART traffic, checked against a queue/array model.
module tb_io_ram_datapath_p;
    localparam logic [31:0] IO_BASE = 32'h0040_0000;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int WORDS   = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] gpio_out;
`ifdef IO_RAM_RX_IRQ_EN
    logic       rx_irq;
`endif

    io_ram_datapath_p_if bus();

    io_ram_datapath_p #(
        .RAM_WORDS(WORDS), .IO_BASE(IO_BASE), .CLK_DIV(CLK_DIV),
        .RX_FIFO_DEPTH(DEPTH), .GPIO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rx(rx), .gpio_out(gpio_out)
`ifdef IO_RAM_RX_IRQ_EN
        , .rx_irq(rx_irq)
`endif
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    logic [31:0] ram_m [WORDS];
    logic [7:0]  gpio_m = 8'h00;
    logic [7:0]  fifo_m [$];
    bit          ov_m = 1'b0, fr_m = 1'b0, irq_en_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= IO_BASE) && ((a - IO_BASE) < 32'd65536);
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] mc);
        return (mc == 2'd1 && a % 2 != 0) || (mc >= 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(fifo_m.size()) * 256 + 32'(fr_m) * 4 + 32'(ov_m) * 2 + 32'(fifo_m.size() != 0);
`ifdef IO_RAM_RX_IRQ_EN
        s = s + 32'(irq_en_m) * 16;
`endif
        return s;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] off;
        if (!in_window(a)) return ram_m[(a / 4) % WORDS];
        off = a - IO_BASE;
        if (off == 0) return 32'(gpio_m);
        if (off == 4) return model_status();
        if (off == 8) return (fifo_m.size() != 0) ? 32'(fifo_m[0]) : 32'd0;
        return 32'd0;
    endfunction

    task automatic model_access(input bit we, input bit re, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] mc);
        logic [31:0] off, w, mask;
        int unsigned idx, sh;
        if (we && !model_mis(a, mc)) begin
            if (in_window(a)) begin
                off = a - IO_BASE;
                if (off == 0 && mc >= 2'd2) gpio_m = wd[7:0];
                if (off == 4) begin
                    if (wd[1]) ov_m = 1'b0;
                    if (wd[2]) fr_m = 1'b0;
                    if (mc >= 2'd2) irq_en_m = wd[4];
                end
            end else begin
                idx = (a / 4) % WORDS;
                w   = ram_m[idx];
                sh  = 8 * (a % 4);
                if (mc == 2'd0) begin
                    mask = 32'hFF << sh;
                    w = (w & ~mask) | ((wd & 32'hFF) << sh);
                end else if (mc == 2'd1) begin
                    mask = 32'hFFFF << sh;
                    w = (w & ~mask) | ((wd & 32'hFFFF) << sh);
                end else begin
                    w = wd;
                end
                ram_m[idx] = w;
            end
        end
        if (re && in_window(a) && (a - IO_BASE) == 8 && fifo_m.size() != 0)
            void'(fifo_m.pop_front());
    endtask

    // Outputs are combinational functions of the bus and pre-edge state; sample mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd", bus.rd, model_rd(bus.address));
            check("misalign", {31'b0, bus.misalign}, {31'b0, model_mis(bus.address, bus.mem_ctrl)});
            check("gpio_out", {24'b0, gpio_out}, {24'b0, gpio_m});
        end
    end

    task automatic op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] mc, output logic [31:0] rd_o, output logic mis_o);
        #1;
        bus.we = we; bus.re = re; bus.address = a; bus.wd = wd; bus.mem_ctrl = mc;
        @(negedge clk);
        rd_o  = bus.rd;
        mis_o = bus.misalign;
        @(posedge clk);
        model_access(we, re, a, wd, mc);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mc);
        logic [31:0] r;
        logic m;
        op(1'b1, 1'b0, a, wd, mc, r, m);
    endtask

    task automatic ld(input logic [31:0] a, input bit re, input logic [31:0] exp, input string name);
        logic [31:0] r;
        logic m;
        op(1'b0, re, a, 32'd0, 2'd2, r, m);
        check(name, r, exp);
    endtask

    task automatic bus_idle();
        bus.we = 1'b0; bus.re = 1'b0; bus.address = 32'd0; bus.wd = 32'd0; bus.mem_ctrl = 2'd2;
    endtask

    task automatic rx_bit(input logic v);
        #1;
        bus_idle();
        rx = v;
        repeat (CLK_DIV) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
        rx_bit(1'b1);
        rx_bit(1'b1);
        if (!stop)                     fr_m = 1'b1;
        else if (fifo_m.size() == DEPTH) ov_m = 1'b1;
        else                            fifo_m.push_back(b);
    endtask

    task automatic model_reset();
        gpio_m = 8'h00;
        fifo_m.delete();
        ov_m = 1'b0; fr_m = 1'b0; irq_en_m = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, a, wd;
        logic m;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_gpio", {24'b0, gpio_out}, 32'd0);
        @(posedge clk);
        ld(IO_BASE + 4, 1'b0, 32'h0, "reset_status");
        ld(IO_BASE + 8, 1'b1, 32'h0, "reset_rxdata_empty");

        for (int i = 0; i < WORDS; i++) st(32'(i * 4), $urandom, 2'd2);
        chk_en = 1'b1;

        st(IO_BASE, 32'h0000_0001, 2'd2);
        @(negedge clk);
        check("gpio_after_store", {24'b0, gpio_out}, 32'h1);
        @(posedge clk);
        ld(IO_BASE, 1'b0, 32'h0000_0001, "gpio_read");
        st(IO_BASE, 32'hFF, 2'd0);
        st(IO_BASE, 32'hFFFF, 2'd1);
        ld(IO_BASE, 1'b0, 32'h0000_0001, "gpio_narrow_ignored");

        st(32'h10, 32'hAABB_CCDD, 2'd2);
        st(32'h12, 32'h11, 2'd0);
        st(32'h14, 32'h0, 2'd2);
        st(32'h14, 32'h2233, 2'd1);
        ld(32'h10, 1'b0, 32'hAA11_CCDD, "ram_byte_merge");
        ld(32'h14, 1'b0, 32'h0000_2233, "ram_half_merge");
        ld(IO_BASE + 32'h10000 + 32'h10, 1'b0, 32'hAA11_CCDD, "ram_alias_above");

        op(1'b1, 1'b0, 32'h12, 32'hDEAD_BEEF, 2'd2, r, m);
        check("misalign_word", {31'b0, m}, 32'h1);
        ld(32'h10, 1'b0, 32'hAA11_CCDD, "misaligned_store_dropped");
        op(1'b0, 1'b0, 32'h13, 32'h0, 2'd1, r, m);
        check("misalign_half", {31'b0, m}, 32'h1);
        check("misaligned_load_word", r, 32'hAA11_CCDD);

        send_frame(8'h5A, 1'b1);
        ld(IO_BASE + 4, 1'b0, 32'h0000_0101, "status_one_byte");
        ld(IO_BASE + 8, 1'b1, 32'h0000_005A, "rxdata_5a");
        ld(IO_BASE + 4, 1'b0, 32'h0000_0000, "status_after_pop");

        for (int b = 1; b <= DEPTH + 1; b++) send_frame(8'(b), 1'b1);
        ld(IO_BASE + 4, 1'b0, 32'h0000_0403, "status_overflow_full");
        for (int b = 1; b <= DEPTH; b++) ld(IO_BASE + 8, 1'b1, 32'(b), "rxdata_fifo_order");
        ld(IO_BASE + 4, 1'b0, 32'h0000_0002, "status_ovf_sticky");
        st(IO_BASE + 4, 32'h2, 2'd2);
        ld(IO_BASE + 4, 1'b0, 32'h0000_0000, "status_ovf_cleared");

        send_frame(8'h3C, 1'b0);
        ld(IO_BASE + 4, 1'b0, 32'h0000_0004, "status_framing");
        st(IO_BASE + 4, 32'h4, 2'd2);
        rx_bit(1'b1);
        #1 rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        ld(IO_BASE + 4, 1'b0, 32'h0000_0000, "glitch_no_byte");

        st(IO_BASE, 32'hA5, 2'd2);
        send_frame(8'h77, 1'b1);
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_bit(1'b0);
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        rx     = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("midframe_reset_gpio", {24'b0, gpio_out}, 32'h0);
        @(posedge clk);
        ld(IO_BASE + 4, 1'b0, 32'h0000_0000, "midframe_reset_status");

        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 14) == 0) begin
                send_frame(8'($urandom), $urandom_range(0, 5) != 0);
            end else begin
                case ($urandom_range(0, 5))
                    0, 1:    a = 32'($urandom_range(0, 1023));
                    2:       a = IO_BASE + 32'h10000 + 32'($urandom_range(0, 1023));
                    3:       a = IO_BASE + 32'(4 * $urandom_range(0, 3));
                    4:       a = IO_BASE + 32'($urandom_range(0, 15));
                    default: a = $urandom;
                endcase
                wd = $urandom;
                op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd,
                   2'($urandom_range(0, 3)), r, m);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
